vend_txn_controller: RTL and testbench

- Transaction sequencer for the vending-machine datapath.
- Accumulates coin credit, validates a product selection against its price, and runs a req/ack handshake with the dispenser.
- Returns leftover or cancelled credit as one change pulse per credit unit.
- Sits between the user inputs (ui_in) and the dispenser/credit display on uo_out, driven by the prescaled internal clock.

---
 rtl/vend_txn_controller.sv | 115 +++++++++++
 tb/tb_vend_txn_controller.sv | 124 ++++++++++++
 2 files changed

// File: rtl/vend_txn_controller.sv
// vend_txn_controller: coin credit, price check, dispenser handshake and unit-by-unit change return
module vend_txn_controller #(
  parameter int CREDIT_W = 3,
  parameter int TMO_W    = 8,
  parameter int TIMEOUT  = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin,
  input  logic                cancel,
  input  logic                sel_valid,
  input  logic [CREDIT_W-1:0] sel,
  input  logic                disp_ack,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                disp_req,
  output logic [CREDIT_W-1:0] disp_prod,
  output logic                change_pulse,
  output logic                insufficient,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;
  localparam logic [CREDIT_W-1:0] MAX_CREDIT = '1;
  state_t state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, prod_q, prod_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic acc_q, acc_d, rej_q, rej_d, req_q, req_d, chg_q, chg_d, ins_q, ins_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      prod_q   <= '0;
      tmo_q    <= '0;
      acc_q    <= 1'b0;
      rej_q    <= 1'b0;
      req_q    <= 1'b0;
      chg_q    <= 1'b0;
      ins_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      prod_q   <= prod_d;
      tmo_q    <= tmo_d;
      acc_q    <= acc_d;
      rej_q    <= rej_d;
      req_q    <= req_d;
      chg_q    <= chg_d;
      ins_q    <= ins_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    prod_d   = prod_q;
    tmo_d    = '0;
    acc_d    = 1'b0;
    rej_d    = 1'b0;
    req_d    = req_q;
    chg_d    = 1'b0;
    ins_d    = 1'b0;
    case (state_q)
      IDLE: if (coin) begin
        state_d  = COLLECT;
        credit_d = CREDIT_W'(1);
        acc_d    = 1'b1;
      end
      COLLECT: begin
        tmo_d = (coin | cancel | sel_valid) ? '0 : tmo_q + TMO_W'(1);
        // cancel > sel_valid > coin; a coin losing to a higher event is refused
        if (cancel) begin
          state_d = CHANGE;
          rej_d   = coin;
        end else if (sel_valid) begin
          rej_d = coin;
          if (sel != '0 && sel <= credit_q) begin
            state_d  = VEND;
            credit_d = credit_q - sel;
            req_d    = 1'b1;
            prod_d   = sel;
          end else
            ins_d = 1'b1;
        end else if (coin) begin
          acc_d    = credit_q != MAX_CREDIT;
          rej_d    = credit_q == MAX_CREDIT;
          credit_d = credit_q != MAX_CREDIT ? credit_q + CREDIT_W'(1) : credit_q;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1))
          state_d = CHANGE;
      end
      VEND: begin
        rej_d = coin;
        if (disp_ack) begin
          req_d   = 1'b0;
          prod_d  = '0;
          state_d = credit_q != '0 ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        rej_d    = coin;
        chg_d    = 1'b1;
        credit_d = credit_q - CREDIT_W'(1);
        state_d  = credit_q == CREDIT_W'(1) ? IDLE : CHANGE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign coin_accept  = acc_q;
  assign coin_reject  = rej_q;
  assign disp_req     = req_q;
  assign disp_prod    = prod_q;
  assign change_pulse = chg_q;
  assign insufficient = ins_q;
  assign credit       = credit_q;
  assign busy         = state_q == VEND || state_q == CHANGE;
endmodule

// File: tb/tb_vend_txn_controller.sv
// tb_vend_txn_controller: directed steps, per-cycle expected outputs queued and checked after each edge
module tb_vend_txn_controller;
  logic clk = 1'b0, reset = 1'b0;
  logic coin = 1'b0, cancel = 1'b0, sel_valid = 1'b0, disp_ack = 1'b0;
  logic [2:0] sel = '0;
  logic coin_accept, coin_reject, disp_req, change_pulse, insufficient, busy;
  logic [2:0] disp_prod, credit;
  int compared = 0, mismatched = 0;
  typedef struct {string tag; logic [11:0] exp;} sb_t;
  sb_t sb[$];

  vend_txn_controller #(.CREDIT_W(3), .TMO_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .coin(coin), .cancel(cancel), .sel_valid(sel_valid),
    .sel(sel), .disp_ack(disp_ack), .coin_accept(coin_accept), .coin_reject(coin_reject),
    .disp_req(disp_req), .disp_prod(disp_prod), .change_pulse(change_pulse),
    .insufficient(insufficient), .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  // {accept, reject, req, prod[2:0], change, insufficient, credit[2:0], busy}
  function automatic logic [11:0] ex(int a, int r, int q, int p, int c, int i, int cr, int b);
    return {a[0], r[0], q[0], p[2:0], c[0], i[0], cr[2:0], b[0]};
  endfunction

  task automatic check();
    sb_t t;
    logic [11:0] obs;
    t = sb.pop_front();
    obs = {coin_accept, coin_reject, disp_req, disp_prod, change_pulse, insufficient, credit, busy};
    compared++;
    assert (obs === t.exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", t.tag, obs, t.exp);
    end
  endtask

  task automatic step(int c, int cn, int sv, int s, int ak, logic [11:0] e, string tag);
    coin = c[0]; cancel = cn[0]; sel_valid = sv[0]; sel = s[2:0]; disp_ack = ak[0];
    sb.push_back('{tag, e});
    @(posedge clk); #1;
    coin = 0; cancel = 0; sel_valid = 0; sel = '0; disp_ack = 0;
    check();
  endtask

  task automatic idle(logic [11:0] e, string tag);
    step(0, 0, 0, 0, 0, e, tag);
  endtask

  initial begin
    #2 reset = 1'b1;
    #2 sb.push_back('{"rst_init", 12'b0}); check();
    @(posedge clk); #1 reset = 1'b0;
    // reset mid-VEND discards credit
    step(1,0,0,0,0, ex(1,0,0,0,0,0,1,0), "a_coin1");
    step(1,0,0,0,0, ex(1,0,0,0,0,0,2,0), "a_coin2");
    step(1,0,0,0,0, ex(1,0,0,0,0,0,3,0), "a_coin3");
    step(0,0,1,1,0, ex(0,0,1,1,0,0,2,1), "a_sel1");
    idle(ex(0,0,1,1,0,0,2,1), "a_hold");
    #2 reset = 1'b1;
    #1 sb.push_back('{"rst_vend", 12'b0}); check();
    @(posedge clk); #1 reset = 1'b0;
    idle(12'b0, "a_post_rst1");
    idle(12'b0, "a_post_rst2");
    // normal vend with one unit of change
    step(1,0,0,0,0, ex(1,0,0,0,0,0,1,0), "b_coin1");
    step(1,0,0,0,0, ex(1,0,0,0,0,0,2,0), "b_coin2");
    step(1,0,0,0,0, ex(1,0,0,0,0,0,3,0), "b_coin3");
    step(0,0,1,2,0, ex(0,0,1,2,0,0,1,1), "b_sel2");
    idle(ex(0,0,1,2,0,0,1,1), "b_wait1");
    idle(ex(0,0,1,2,0,0,1,1), "b_wait2");
    step(0,1,1,3,0, ex(0,0,1,2,0,0,1,1), "b_wait3_ignored");
    step(0,0,0,0,1, ex(0,0,0,0,0,0,1,1), "b_ack");
    idle(ex(0,0,0,0,1,0,0,0), "b_change");
    step(0,0,0,0,1, 12'b0, "b_idle_ack_ignored");
    // insufficient then cancel
    step(1,0,0,0,0, ex(1,0,0,0,0,0,1,0), "c_coin1");
    step(1,0,0,0,0, ex(1,0,0,0,0,0,2,0), "c_coin2");
    step(0,0,1,5,0, ex(0,0,0,0,0,1,2,0), "c_insuff");
    step(0,1,0,0,0, ex(0,0,0,0,0,0,2,1), "c_cancel");
    idle(ex(0,0,0,0,1,0,1,1), "c_chg1");
    idle(ex(0,0,0,0,1,0,0,0), "c_chg2");
    idle(12'b0, "c_done");
    // saturation at MAX_CREDIT, coins refused while busy
    for (int i = 1; i <= 7; i++) step(1,0,0,0,0, ex(1,0,0,0,0,0,i,0), $sformatf("d_coin%0d", i));
    step(1,0,0,0,0, ex(0,1,0,0,0,0,7,0), "d_coin8_sat");
    step(0,0,1,0,0, ex(0,0,0,0,0,1,7,0), "d_sel0");
    step(0,0,1,3,0, ex(0,0,1,3,0,0,4,1), "d_sel3");
    step(1,0,0,0,0, ex(0,1,1,3,0,0,4,1), "d_coin_vend");
    step(0,0,0,0,1, ex(0,0,0,0,0,0,4,1), "d_ack");
    step(1,0,0,0,0, ex(0,1,0,0,1,0,3,1), "d_chg1_coin");
    idle(ex(0,0,0,0,1,0,2,1), "d_chg2");
    idle(ex(0,0,0,0,1,0,1,1), "d_chg3");
    idle(ex(0,0,0,0,1,0,0,0), "d_chg4");
    // same-cycle priority
    step(1,0,0,0,0, ex(1,0,0,0,0,0,1,0), "e_coin");
    step(1,0,1,1,0, ex(0,1,1,1,0,0,0,1), "e_coin_sel");
    step(0,0,0,0,1, ex(0,0,0,0,0,0,0,0), "e_ack_to_idle");
    step(1,0,0,0,0, ex(1,0,0,0,0,0,1,0), "e_coin2");
    step(0,1,1,1,0, ex(0,0,0,0,0,0,1,1), "e_cancel_sel");
    idle(ex(0,0,0,0,1,0,0,0), "e_chg");
    // inactivity timeout, and a coin restarting the count
    step(1,0,0,0,0, ex(1,0,0,0,0,0,1,0), "f_coin");
    for (int i = 1; i <= 3; i++) idle(ex(0,0,0,0,0,0,1,0), $sformatf("f_idle%0d", i));
    idle(ex(0,0,0,0,0,0,1,1), "f_timeout");
    idle(ex(0,0,0,0,1,0,0,0), "f_chg");
    step(1,0,0,0,0, ex(1,0,0,0,0,0,1,0), "g_coin1");
    idle(ex(0,0,0,0,0,0,1,0), "g_idle1");
    idle(ex(0,0,0,0,0,0,1,0), "g_idle2");
    step(1,0,0,0,0, ex(1,0,0,0,0,0,2,0), "g_coin_restart");
    for (int i = 1; i <= 3; i++) idle(ex(0,0,0,0,0,0,2,0), $sformatf("g_idle_r%0d", i));
    idle(ex(0,0,0,0,0,0,2,1), "g_timeout");
    idle(ex(0,0,0,0,1,0,1,1), "g_chg1");
    idle(ex(0,0,0,0,1,0,0,0), "g_chg2");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, required finish before 50000");
    $fatal(1, "watchdog expired");
  end
endmodule
